// File: rtl/icache.sv
// Direct-mapped instruction cache between IF and MemCtrl: single-cycle hits,
// 4-word line refill through word reads on a miss. Read-only, no write path.
//
// state  | meaning
// IDLE   | accept fetch pulses; a hit is answered next cycle
// REFILL | reading the 4 words of the missed line, ascending
// RESP   | one-cycle response (withheld if cancelled), then back to IDLE
module icache #(
   parameter int INDEX_WIDTH = 6
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic        fetch_valid_if_in,
   input  logic [31:0] fetch_addr_if_in,
   output logic        stall_if_out,
   output logic        inst_rdy_if_out,
   output logic [31:0] inst_if_out,
   input  logic        clear_in,
   output logic        mem_req_mc_out,
   output logic [31:0] mem_addr_mc_out,
   input  logic        mem_rdy_mc_in,
   input  logic [31:0] mem_data_mc_in
);

   localparam int LINES     = 1 << INDEX_WIDTH;
   localparam int TAG_WIDTH = 28 - INDEX_WIDTH;

   typedef enum logic [1:0] {IDLE, REFILL, RESP} state_t;

   state_t                 state;
   logic [LINES-1:0]       valid;
   logic [TAG_WIDTH-1:0]   tags  [LINES];
   logic [31:0]            words [LINES][4];

   logic [31:2]            addr_q;
   logic [1:0]             cnt;
   logic [1:0]             cnt_next;
   logic                   cancel;

   logic [INDEX_WIDTH-1:0] f_index;
   logic [INDEX_WIDTH-1:0] r_index;
   logic [TAG_WIDTH-1:0]   f_tag;
   logic [TAG_WIDTH-1:0]   r_tag;
   logic [1:0]             f_off;
   logic [1:0]             r_off;
   logic                   hit;
   logic                   fill_beat;
   logic                   drop;
   logic [31:0]            resp_word;
   logic                   unused_addr_bits;

   assign f_off    = fetch_addr_if_in[3:2];
   assign f_index  = fetch_addr_if_in[3+INDEX_WIDTH:4];
   assign f_tag    = fetch_addr_if_in[31:4+INDEX_WIDTH];
   assign r_off    = addr_q[3:2];
   assign r_index  = addr_q[3+INDEX_WIDTH:4];
   assign r_tag    = addr_q[31:4+INDEX_WIDTH];
   assign unused_addr_bits = ^fetch_addr_if_in[1:0];

   assign hit       = valid[f_index] && (tags[f_index] == f_tag);
   assign fill_beat = rdy_in && (state == REFILL) && mem_rdy_mc_in;
   assign drop      = cancel || clear_in;
   assign cnt_next  = cnt + 2'd1;
   // The last word is still on the bus when the response is registered.
   assign resp_word = (r_off == 2'd3) ? mem_data_mc_in : words[r_index][r_off];

   always_ff @(posedge clk_in) begin
      if (!rst_in && fill_beat) begin
         words[r_index][cnt] <= mem_data_mc_in;
         if (cnt == 2'd3) begin
            tags[r_index] <= r_tag;
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state           <= IDLE;
         valid           <= '0;
         addr_q          <= '0;
         cnt             <= '0;
         cancel          <= 1'b0;
         stall_if_out    <= 1'b0;
         inst_rdy_if_out <= 1'b0;
         inst_if_out     <= '0;
         mem_req_mc_out  <= 1'b0;
         mem_addr_mc_out <= '0;
      end else if (rdy_in) begin
         case (state)
            IDLE: begin
               cancel          <= 1'b0;
               inst_rdy_if_out <= 1'b0;
               if (fetch_valid_if_in && !clear_in) begin
                  if (hit) begin
                     inst_if_out     <= words[f_index][f_off];
                     inst_rdy_if_out <= 1'b1;
                  end else begin
                     addr_q          <= fetch_addr_if_in[31:2];
                     cnt             <= '0;
                     stall_if_out    <= 1'b1;
                     mem_req_mc_out  <= 1'b1;
                     mem_addr_mc_out <= {fetch_addr_if_in[31:4], 4'h0};
                     state           <= REFILL;
                  end
               end
            end
            REFILL: begin
               cancel <= drop;
               if (mem_rdy_mc_in) begin
                  cnt <= cnt_next;
                  if (cnt == 2'd3) begin
                     valid[r_index] <= 1'b1;
                     mem_req_mc_out <= 1'b0;
                     state          <= RESP;
                     if (!drop) begin
                        inst_if_out     <= resp_word;
                        inst_rdy_if_out <= 1'b1;
                     end
                  end else begin
                     mem_addr_mc_out <= {addr_q[31:4], cnt_next, 2'b00};
                  end
               end
            end
            RESP: begin
               inst_rdy_if_out <= 1'b0;
               stall_if_out    <= 1'b0;
               cancel          <= 1'b0;
               state           <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed scenarios followed by random fetches,
// checked against a line-level cache model and a latency-programmable memory responder.
module tb_icache;

   localparam int IW = 6;
   localparam logic [31:0] NOPAUSE = 32'hFFFF_FFFF;

   logic        clk;
   logic        rst;
   logic        rdy;
   logic        fetch_valid;
   logic [31:0] fetch_addr;
   logic        stall;
   logic        inst_rdy;
   logic [31:0] inst;
   logic        clear;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_rdy;
   logic [31:0] mem_data;

   int checks = 0;
   int errors = 0;

   bit          ref_valid [64];
   logic [21:0] ref_tag   [64];
   logic [31:0] rd_log[$];
   int          lat_max = 1;

   icache #(.INDEX_WIDTH(IW)) dut (
      .clk_in           (clk),
      .rst_in           (rst),
      .rdy_in           (rdy),
      .fetch_valid_if_in(fetch_valid),
      .fetch_addr_if_in (fetch_addr),
      .stall_if_out     (stall),
      .inst_rdy_if_out  (inst_rdy),
      .inst_if_out      (inst),
      .clear_in         (clear),
      .mem_req_mc_out   (mem_req),
      .mem_addr_mc_out  (mem_addr),
      .mem_rdy_mc_in    (mem_rdy),
      .mem_data_mc_in   (mem_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog expired at time %0t", $time);
      $fatal(1);
   end

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      logic [31:0] w;
      w = a & 32'hFFFF_FFFC;
      case (w)
         32'h0:   return 32'h0000_0013;
         32'h4:   return 32'h0010_0093;
         32'h8:   return 32'h0020_0113;
         32'hC:   return 32'h0030_0193;
         default: return (w * 32'h9E37_79B1) ^ 32'h5A5A_0000;
      endcase
   endfunction

   // MemCtrl stand-in: answers each word after lat_max-bounded cycles, frozen while rdy is low.
   initial begin
      bit took;
      bit rdy_seen;
      int lat;
      lat = 1;
      mem_rdy = 1'b0;
      mem_data = '0;
      forever begin
         @(posedge clk);
         took = mem_rdy && rdy && !rst;
         rdy_seen = rdy;
         @(negedge clk);
         #1;
         if (took) begin
            mem_rdy = 1'b0;
            lat = $urandom_range(1, lat_max);
         end else if (rst || !mem_req) begin
            mem_rdy = 1'b0;
         end else if (!mem_rdy) begin
            if (lat == 0) begin
               mem_rdy  = 1'b1;
               mem_data = mem_word(mem_addr);
               rd_log.push_back(mem_addr);
            end else if (rdy_seen) begin
               lat--;
            end
         end
      end
   end

   task automatic step();
      @(negedge clk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      foreach (ref_valid[i]) ref_valid[i] = 1'b0;
   endtask

   task automatic check_line_reads(input string tag, input logic [31:0] base);
      chk({tag, "_nreads"}, rd_log.size(), 4);
      for (int k = 0; k < 4; k++) begin
         if (k < rd_log.size()) chk({tag, "_raddr"}, rd_log[k], base + 32'(4 * k));
      end
   endtask

   // Issue one fetch from IDLE and check the full response against the model.
   task automatic do_fetch(input logic [31:0] a, input bit clr, input logic [31:0] pause_at,
                           output int n);
      logic [31:0] base;
      int          idx;
      logic [21:0] tg;
      bit          hit;
      bit          paused;
      base = a & 32'hFFFF_FFF0;
      idx  = int'((a >> 4) & 32'h3F);
      tg   = a[31:10];
      hit  = ref_valid[idx] && (ref_tag[idx] == tg);
      paused = 1'b0;
      rd_log.delete();
      fetch_valid = 1'b1;
      fetch_addr  = a;
      clear       = clr;
      step();
      n = 1;
      fetch_valid = 1'b0;
      clear       = 1'b0;
      if (clr) begin
         chk("drop_rdy", inst_rdy, 0);
         chk("drop_stall", stall, 0);
         chk("drop_req", mem_req, 0);
      end else if (hit) begin
         chk("hit_rdy", inst_rdy, 1);
         chk("hit_word", inst, mem_word(a));
         chk("hit_stall", stall, 0);
         chk("hit_noreq", mem_req, 0);
      end else begin
         chk("miss_stall", stall, 1);
         chk("miss_req", mem_req, 1);
         chk("miss_addr0", mem_addr, base);
         while (!inst_rdy && n < 200) begin
            if (!paused && mem_req && mem_addr == pause_at) begin
               paused = 1'b1;
               rdy = 1'b0;
               repeat (3) begin
                  step();
                  n++;
                  chk("pause_addr", mem_addr, pause_at);
                  chk("pause_req", mem_req, 1);
               end
               rdy = 1'b1;
            end
            step();
            n++;
         end
         chk("miss_rdy", inst_rdy, 1);
         chk("miss_word", inst, mem_word(a));
         chk("miss_stall_resp", stall, 1);
         check_line_reads("miss", base);
         step();
         chk("miss_single_pulse", inst_rdy, 0);
         chk("miss_stall_done", stall, 0);
         chk("miss_req_done", mem_req, 0);
         ref_valid[idx] = 1'b1;
         ref_tag[idx]   = tg;
      end
   endtask

   initial begin
      int n;
      int beats;
      bit saw_rdy;
      logic [31:0] a;
      bit clr;

      rst = 1'b1;
      rdy = 1'b1;
      fetch_valid = 1'b0;
      fetch_addr = '0;
      clear = 1'b0;
      model_reset();
      repeat (3) step();
      rst = 1'b0;
      chk("rst_stall", stall, 0);
      chk("rst_inst_rdy", inst_rdy, 0);
      chk("rst_inst", inst, 0);
      chk("rst_req", mem_req, 0);
      chk("rst_addr", mem_addr, 0);
      step();

      // cold miss with the fixed-latency responder: response on the 12th cycle
      do_fetch(32'h0, 1'b0, NOPAUSE, n);
      chk("cold_latency", n, 12);
      chk("cold_word", inst, 32'h0000_0013);

      // back-to-back hits
      fetch_valid = 1'b1;
      fetch_addr  = 32'h8;
      step();
      chk("hit8_rdy", inst_rdy, 1);
      chk("hit8_word", inst, 32'h0020_0113);
      chk("hit8_noreq", mem_req, 0);
      fetch_addr = 32'hC;
      step();
      fetch_valid = 1'b0;
      chk("hitC_rdy", inst_rdy, 1);
      chk("hitC_word", inst, 32'h0030_0193);
      chk("hitC_noreq", mem_req, 0);
      step();
      chk("hit_pulse_end", inst_rdy, 0);

      // conflict eviction on index 0
      do_fetch(32'h400, 1'b0, NOPAUSE, n);
      do_fetch(32'h4, 1'b0, NOPAUSE, n);
      step();

      // clear during refill: line still fills, no response
      rd_log.delete();
      fetch_valid = 1'b1;
      fetch_addr  = 32'h100;
      step();
      fetch_valid = 1'b0;
      beats = 0;
      n = 0;
      saw_rdy = 1'b0;
      while (stall && n < 200) begin
         if (mem_rdy) begin
            beats++;
            if (beats == 2) clear = 1'b1;
         end
         step();
         clear = 1'b0;
         n++;
         if (inst_rdy) saw_rdy = 1'b1;
      end
      chk("clr_stall_done", stall, 0);
      chk("clr_no_rdy", saw_rdy, 0);
      check_line_reads("clr", 32'h100);
      ref_valid[16] = 1'b1;
      ref_tag[16]   = '0;
      do_fetch(32'h104, 1'b0, NOPAUSE, n);
      chk("clr_then_hit", n, 1);
      step();

      // pause while the second word is requested
      do_fetch(32'h200, 1'b0, 32'h204, n);
      chk("pause_latency", n, 15);
      step();

      // reset after two words of line 0x300
      rd_log.delete();
      fetch_valid = 1'b1;
      fetch_addr  = 32'h300;
      step();
      fetch_valid = 1'b0;
      beats = 0;
      n = 0;
      while (beats < 2 && n < 200) begin
         if (mem_rdy) beats++;
         step();
         n++;
      end
      chk("rstmid_beats", beats, 2);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rstmid_req", mem_req, 0);
      chk("rstmid_stall", stall, 0);
      chk("rstmid_rdy", inst_rdy, 0);
      model_reset();
      step();
      do_fetch(32'h300, 1'b0, NOPAUSE, n);
      chk("rstmid_refetch_miss", (n > 1), 1);
      step();

      // random fetches over a small footprint to mix hits, misses and conflicts
      lat_max = 3;
      for (int i = 0; i < 60; i++) begin
         a = {20'h0, 2'($urandom_range(0, 3)), 4'h0, 2'($urandom_range(0, 3)),
              2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
         clr = ($urandom_range(0, 7) == 0);
         do_fetch(a, clr, NOPAUSE, n);
         repeat ($urandom_range(0, 2)) step();
      end
      step();
      chk("final_idle_stall", stall, 0);
      chk("final_idle_req", mem_req, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
